// File: rtl/btn_event_pkg.sv
// Shared types and widths for the push-button gesture decoder.
package btn_event_pkg;

  localparam int unsigned TICK_CNT_W = 16;
  localparam int unsigned PRESC_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESSED   = 3'd1,
    ST_LONG_HELD = 3'd2,
    ST_WAIT_2ND  = 3'd3,
    ST_PRESSED2  = 3'd4
  } state_e;

  // States in which the button is physically down.
  function automatic logic is_held(input state_e s);
    return (s == ST_PRESSED) || (s == ST_LONG_HELD) || (s == ST_PRESSED2);
  endfunction

endpackage

// File: rtl/button_event_decoder_tick_prescaler.sv
// Divides CLK_O down to a one-cycle timing tick; clear may seed one elapsed cycle.
module tick_prescaler
  import btn_event_pkg::*;
#(
  parameter logic [31:0] TICK_DIV = 32'd50000
) (
  input  logic CLK_O,
  input  logic XRST,
  input  logic clr_i,
  input  logic seed_i,
  output logic tick_c
);

  localparam logic [PRESC_W-1:0] LAST     = PRESC_W'(TICK_DIV - 32'd1);
  localparam logic [PRESC_W-1:0] SEED_VAL = (TICK_DIV > 32'd1) ? PRESC_W'(1) : PRESC_W'(0);

  logic [PRESC_W-1:0] presc_q, presc_d;

  assign tick_c = (presc_q == LAST);

  always_comb begin
    presc_d = presc_q;
    if (clr_i) begin
      presc_d = seed_i ? SEED_VAL : '0;
    end else if (tick_c) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge CLK_O or negedge XRST) begin
    if (!XRST) presc_q <= '0;
    else       presc_q <= presc_d;
  end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced press/release pulses into short, long(+repeat) and double gestures.
module button_event_decoder
  import btn_event_pkg::*;
#(
  parameter logic [31:0] TICK_DIV     = 32'd50000,
  parameter logic [15:0] LONG_TICKS   = 16'd800,
  parameter logic [15:0] DBL_TICKS    = 16'd300,
  parameter logic [15:0] REPEAT_TICKS = 16'd200
) (
  input  logic CLK_O,
  input  logic XRST,
  input  logic EN_I,
  input  logic PRESS_I,
  input  logic RELEASE_I,
  output logic SHORT_O,
  output logic LONG_O,
  output logic REPEAT_O,
  output logic DOUBLE_O,
  output logic HELD_O
);

  localparam int unsigned CMP_W = TICK_CNT_W + 1;
  // An edge-started interval already counts its sampling cycle; with TICK_DIV=1
  // that cycle is a whole tick.
  localparam logic [TICK_CNT_W-1:0] TICK_SEED =
    (TICK_DIV == 32'd1) ? TICK_CNT_W'(1) : TICK_CNT_W'(0);

  state_e                  state_q, state_d;
  logic [TICK_CNT_W-1:0]   ticks_q, ticks_d;
  logic                    short_q, short_d, long_q, long_d;
  logic                    repeat_q, repeat_d, double_q, double_d;
  logic                    held_q, held_d;
  logic                    clr_c, seed_c, tick_c;
  logic                    press_c, release_c;
  logic [CMP_W-1:0]        ticks_inc_c;
  logic                    long_hit_c, dbl_hit_c, rep_hit_c;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .CLK_O  (CLK_O),
    .XRST   (XRST),
    .clr_i  (clr_c),
    .seed_i (seed_c),
    .tick_c (tick_c)
  );

  // Simultaneous press and release is a protocol violation and is dropped.
  assign press_c   = PRESS_I & ~RELEASE_I;
  assign release_c = RELEASE_I & ~PRESS_I;

  assign ticks_inc_c = CMP_W'(ticks_q) + CMP_W'(1);
  assign long_hit_c  = tick_c && (ticks_inc_c >= CMP_W'(LONG_TICKS));
  assign dbl_hit_c   = tick_c && (ticks_inc_c >= CMP_W'(DBL_TICKS));
  assign rep_hit_c   = tick_c && (ticks_inc_c >= CMP_W'(REPEAT_TICKS));

  // Next-state, timer control and pulse decode.
  always_comb begin
    state_d  = state_q;
    clr_c    = 1'b0;
    seed_c   = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    double_d = 1'b0;
    if (!EN_I) begin
      state_d = ST_IDLE;
      clr_c   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_c) begin
            state_d = ST_PRESSED;
            clr_c   = 1'b1;
            seed_c  = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (release_c) begin
            state_d = ST_WAIT_2ND;
            clr_c   = 1'b1;
            seed_c  = 1'b1;
          end else if (long_hit_c) begin
            state_d = ST_LONG_HELD;
            long_d  = 1'b1;
            clr_c   = 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (release_c) begin
            state_d = ST_IDLE;
            clr_c   = 1'b1;
            seed_c  = 1'b1;
          end else if (rep_hit_c) begin
            repeat_d = 1'b1;
            clr_c    = 1'b1;
          end
        end
        ST_WAIT_2ND: begin
          if (press_c) begin
            state_d = ST_PRESSED2;
            clr_c   = 1'b1;
            seed_c  = 1'b1;
          end else if (dbl_hit_c) begin
            state_d = ST_IDLE;
            short_d = 1'b1;
            clr_c   = 1'b1;
          end
        end
        ST_PRESSED2: begin
          if (release_c) begin
            state_d  = ST_IDLE;
            double_d = 1'b1;
            clr_c    = 1'b1;
            seed_c   = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          clr_c   = 1'b1;
        end
      endcase
    end
  end

  // Saturating tick counter, restarted with the prescaler.
  always_comb begin
    ticks_d = ticks_q;
    if (clr_c) begin
      ticks_d = seed_c ? TICK_SEED : '0;
    end else if (tick_c && (ticks_q != '1)) begin
      ticks_d = ticks_q + TICK_CNT_W'(1);
    end
  end

  assign held_d = is_held(state_d);

  always_ff @(posedge CLK_O or negedge XRST) begin
    if (!XRST) begin
      state_q  <= ST_IDLE;
      ticks_q  <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ticks_q  <= ticks_d;
      short_q  <= short_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      double_q <= double_d;
      held_q   <= held_d;
    end
  end

  assign SHORT_O  = short_q;
  assign LONG_O   = long_q;
  assign REPEAT_O = repeat_q;
  assign DOUBLE_O = double_q;
  assign HELD_O   = held_q;

endmodule
